// File: rtl/rc6_pkg.sv
// Shared RC6 controller definitions: sequencer states, port widths and
// helpers deriving key-schedule sizes from the round count.
package rc6_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_UNPOST,
        ST_ROUNDS,
        ST_UNPRE,
        ST_DONE
    } rc6_state_e;

    localparam int KEY_ADDR_W = 6;
    localparam int PAIR_IDX_W = 5;
    localparam int STEP_W     = 8;

    localparam int DEFAULT_ROUNDS = 20;
    localparam int NUM_KEYS       = 2 * DEFAULT_ROUNDS + 4;
    localparam int KEY_EXP_STEPS  = 3 * NUM_KEYS;

    function automatic int rc6_num_keys(input int rounds);
        return 2 * rounds + 4;
    endfunction

    function automatic int rc6_key_exp_steps(input int rounds);
        return 3 * rc6_num_keys(rounds);
    endfunction

endpackage

// File: rtl/rc6_key_addr_gen.sv
// Address and step counters for the RC6 sequencer: wrapping key RAM write
// address, loadable down-counting round-key pair index and key-expansion
// step counter with terminal-count flag.
module rc6_key_addr_gen
    import rc6_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  step_en_i,
    input  logic                  pair_load_i,
    input  logic                  pair_dec_i,
    output logic [KEY_ADDR_W-1:0] wr_addr_o,
    output logic [PAIR_IDX_W-1:0] pair_idx_o,
    output logic                  step_tc_o
);

    localparam int NKEYS  = rc6_num_keys(ROUNDS);
    localparam int NSTEPS = rc6_key_exp_steps(ROUNDS);

    logic [KEY_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PAIR_IDX_W-1:0] pair_q, pair_d;
    logic [STEP_W-1:0]     step_q, step_d;

    // Next-count logic: address wraps by compare rather than modulo; pair index saturates at 0.
    always_comb begin
        wr_addr_d = wr_addr_q;
        step_d    = step_q;
        pair_d    = pair_q;
        if (start_i) begin
            wr_addr_d = '0;
            step_d    = '0;
        end else if (step_en_i) begin
            wr_addr_d = (wr_addr_q == KEY_ADDR_W'(NKEYS - 1)) ? '0 : wr_addr_q + 1'b1;
            step_d    = step_q + 1'b1;
        end
        if (pair_load_i) begin
            pair_d = PAIR_IDX_W'(ROUNDS + 1);
        end else if (pair_dec_i && (pair_q != '0)) begin
            pair_d = pair_q - 1'b1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q <= '0;
            step_q    <= '0;
            pair_q    <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            step_q    <= step_d;
            pair_q    <= pair_d;
        end
    end

    assign wr_addr_o  = wr_addr_q;
    assign pair_idx_o = pair_q;
    assign step_tc_o  = (step_q == STEP_W'(NSTEPS - 1));

endmodule

// File: rtl/rc6_decrypt_control.sv
// RC6-32/R/b decryption sequencer: accepts key/ciphertext load requests,
// runs the key schedule once per new key, then steps the datapath through
// undo-post-whitening, R inverse rounds (descending) and undo-pre-whitening.
// ROUNDS must lie in 1..30 so the address and pair-index ports can hold it.
module rc6_decrypt_control
    import rc6_pkg::*;
#(
    parameter int ROUNDS = 20
) (
    input  logic       inClk,
    input  logic       inReset,
    input  logic       inKeyWr,
    input  logic       inDataWr,
    output logic       outKeyExtWr,
    output logic       outKeyIntWr,
    output logic [5:0] outKeyWrAddr,
    output logic [4:0] outKeyPairIdx,
    output logic       outDataExtWr,
    output logic       outDataIntWr,
    output logic       outMode1,
    output logic       outMode2,
    output logic       outBusy,
    output logic       outValid,
    output logic       outKeyValid
);

    rc6_state_e state_q, state_d;
    logic key_valid_q, key_valid_d;
    logic pend_q, pend_d;
    logic key_int_wr_q, key_int_wr_d;
    logic data_int_wr_q, data_int_wr_d;
    logic mode1_q, mode1_d;
    logic mode2_q, mode2_d;
    logic busy_q, busy_d;
    logic valid_q, valid_d;

    logic start, step_en, pair_load, pair_dec, step_tc;
    logic idle;

    rc6_key_addr_gen #(
        .ROUNDS (ROUNDS)
    ) u_addr_gen (
        .clk         (inClk),
        .rst         (inReset),
        .start_i     (start),
        .step_en_i   (step_en),
        .pair_load_i (pair_load),
        .pair_dec_i  (pair_dec),
        .wr_addr_o   (outKeyWrAddr),
        .pair_idx_o  (outKeyPairIdx),
        .step_tc_o   (step_tc)
    );

    assign idle         = (state_q == ST_IDLE);
    // Bus load strobes are only honoured in IDLE; reset wins over a request.
    assign outKeyExtWr  = idle & inKeyWr & ~inReset;
    assign outDataExtWr = idle & inDataWr & (inKeyWr | key_valid_q) & ~inReset;

    // Next-state, counter controls and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        pend_d      = pend_q;
        start       = 1'b0;
        step_en     = 1'b0;
        pair_load   = 1'b0;
        pair_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inKeyWr) begin
                    state_d     = ST_KEYEXP;
                    key_valid_d = 1'b0;
                    pend_d      = inDataWr;
                    start       = 1'b1;
                end else if (inDataWr && key_valid_q) begin
                    state_d   = ST_UNPOST;
                    pair_load = 1'b1;
                end
            end
            ST_KEYEXP: begin
                step_en = 1'b1;
                if (step_tc) begin
                    key_valid_d = 1'b1;
                    state_d     = pend_q ? ST_UNPOST : ST_IDLE;
                    pair_load   = pend_q;
                end
            end
            ST_UNPOST: begin
                pair_dec = 1'b1;
                state_d  = ST_ROUNDS;
            end
            ST_ROUNDS: begin
                pair_dec = 1'b1;
                if (outKeyPairIdx == 5'd1) begin
                    state_d = ST_UNPRE;
                end
            end
            ST_UNPRE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        key_int_wr_d  = (state_d == ST_KEYEXP);
        data_int_wr_d = (state_d == ST_UNPOST) || (state_d == ST_ROUNDS) || (state_d == ST_UNPRE);
        mode1_d       = (state_d == ST_UNPOST);
        mode2_d       = (state_d == ST_UNPRE);
        valid_d       = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any operation and distrusts the key RAM.
    always_ff @(posedge inClk) begin
        if (inReset) begin
            state_q       <= ST_IDLE;
            key_valid_q   <= 1'b0;
            pend_q        <= 1'b0;
            key_int_wr_q  <= 1'b0;
            data_int_wr_q <= 1'b0;
            mode1_q       <= 1'b0;
            mode2_q       <= 1'b0;
            busy_q        <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_valid_q   <= key_valid_d;
            pend_q        <= pend_d;
            key_int_wr_q  <= key_int_wr_d;
            data_int_wr_q <= data_int_wr_d;
            mode1_q       <= mode1_d;
            mode2_q       <= mode2_d;
            busy_q        <= busy_d;
            valid_q       <= valid_d;
        end
    end

    assign outKeyIntWr  = key_int_wr_q;
    assign outDataIntWr = data_int_wr_q;
    assign outMode1     = mode1_q;
    assign outMode2     = mode2_q;
    assign outBusy      = busy_q;
    assign outValid     = valid_q;
    assign outKeyValid  = key_valid_q;

endmodule

// File: tb/tb_rc6_decrypt_control.sv
// Self-checking bench for rc6_decrypt_control (R=20): a cycle timeline model
// fills a scoreboard queue when a request is driven; each scenario pops and
// compares one expected output snapshot per cycle.
module tb_rc6_decrypt_control;

    localparam int R      = 20;
    localparam int NK     = 2 * R + 4;
    localparam int KSTEPS = 3 * NK;

    typedef struct packed {
        logic       busy;
        logic       kint;
        logic [5:0] addr;
        logic [4:0] pair;
        logic       dint;
        logic       m1;
        logic       m2;
        logic       vld;
        logic       kv;
    } obs_t;

    logic       clk = 1'b0;
    logic       inReset, inKeyWr, inDataWr;
    logic       outKeyExtWr, outKeyIntWr, outDataExtWr, outDataIntWr;
    logic [5:0] outKeyWrAddr;
    logic [4:0] outKeyPairIdx;
    logic       outMode1, outMode2, outBusy, outValid, outKeyValid;

    int   n_cmp  = 0;
    int   n_fail = 0;
    obs_t sb[$];
    obs_t o, e;

    rc6_decrypt_control #(.ROUNDS(R)) dut (
        .inClk         (clk),
        .inReset       (inReset),
        .inKeyWr       (inKeyWr),
        .inDataWr      (inDataWr),
        .outKeyExtWr   (outKeyExtWr),
        .outKeyIntWr   (outKeyIntWr),
        .outKeyWrAddr  (outKeyWrAddr),
        .outKeyPairIdx (outKeyPairIdx),
        .outDataExtWr  (outDataExtWr),
        .outDataIntWr  (outDataIntWr),
        .outMode1      (outMode1),
        .outMode2      (outMode2),
        .outBusy       (outBusy),
        .outValid      (outValid),
        .outKeyValid   (outKeyValid)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t s;
        s.busy = outBusy;      s.kint = outKeyIntWr;  s.addr = outKeyWrAddr;
        s.pair = outKeyPairIdx; s.dint = outDataIntWr; s.m1 = outMode1;
        s.m2 = outMode2;       s.vld = outValid;      s.kv = outKeyValid;
        return s;
    endfunction

    // Expected outputs in cycle c after a request accepted at edge 0.
    function automatic obs_t model(int c, bit kexp, bit data, bit kv0);
        obs_t x;
        int   base;
        x    = '0;
        base = kexp ? KSTEPS : 0;
        x.kv = kexp ? (c > KSTEPS) : kv0;
        if (kexp && c >= 1 && c <= KSTEPS) begin
            x.busy = 1'b1; x.kint = 1'b1; x.addr = 6'((c - 1) % NK);
        end else if (data && c == base + 1) begin
            x.busy = 1'b1; x.dint = 1'b1; x.m1 = 1'b1; x.pair = 5'(R + 1);
        end else if (data && c >= base + 2 && c <= base + R + 1) begin
            x.busy = 1'b1; x.dint = 1'b1; x.pair = 5'(R - (c - base - 2));
        end else if (data && c == base + R + 2) begin
            x.busy = 1'b1; x.dint = 1'b1; x.m2 = 1'b1; x.pair = 5'd0;
        end else if (data && c == base + R + 3) begin
            x.busy = 1'b1; x.vld = 1'b1;
        end
        return x;
    endfunction

    task automatic test_reset();
        inReset = 1'b1; inKeyWr = 1'b0; inDataWr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('0);
        o = sample(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_fail++; $display("FAIL reset_state obs=%h exp=%h", o, e); end
        n_cmp++;
        if ({outKeyExtWr, outDataExtWr} !== 2'b00) begin
            n_fail++; $display("FAIL reset_strobes obs=%b exp=00", {outKeyExtWr, outDataExtWr});
        end
        @(negedge clk); inReset = 1'b0;
    endtask

    task automatic test_data_without_key();
        @(negedge clk); inDataWr = 1'b1; #1;
        n_cmp++;
        if (outDataExtWr !== 1'b0) begin n_fail++; $display("FAIL nokey_ext obs=%b exp=0", outDataExtWr); end
        for (int c = 1; c <= 4; c++) sb.push_back(model(c, 0, 0, 0));
        @(posedge clk); #1; inDataWr = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            o = sample(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL nokey c=%0d obs=%h exp=%h", c, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_full_request();
        @(negedge clk); inKeyWr = 1'b1; inDataWr = 1'b1; #1;
        n_cmp++;
        if ({outKeyExtWr, outDataExtWr} !== 2'b11) begin
            n_fail++; $display("FAIL full_ext obs=%b exp=11", {outKeyExtWr, outDataExtWr});
        end
        for (int c = 1; c <= KSTEPS + R + 4; c++) sb.push_back(model(c, 1, 1, 0));
        @(posedge clk); #1; inKeyWr = 1'b0; inDataWr = 1'b0;
        for (int c = 1; c <= KSTEPS + R + 4; c++) begin
            o = sample(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL full c=%0d obs=%h exp=%h", c, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_data_only();
        @(negedge clk); inDataWr = 1'b1; #1;
        n_cmp++;
        if ({outKeyExtWr, outDataExtWr} !== 2'b01) begin
            n_fail++; $display("FAIL donly_ext obs=%b exp=01", {outKeyExtWr, outDataExtWr});
        end
        for (int c = 1; c <= R + 4; c++) sb.push_back(model(c, 0, 1, 1));
        @(posedge clk); #1; inDataWr = 1'b0;
        for (int c = 1; c <= R + 4; c++) begin
            o = sample(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL donly c=%0d obs=%h exp=%h", c, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); inDataWr = 1'b1;
        for (int c = 1; c <= R + 4; c++) sb.push_back(model(c, 0, 1, 1));
        for (int c = 1; c <= R + 4; c++) sb.push_back(model(c, 0, 1, 1));
        @(posedge clk); #1; inDataWr = 1'b0;
        for (int c = 1; c <= 2 * (R + 4); c++) begin
            o = sample(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL b2b c=%0d obs=%h exp=%h", c, o, e); end
            if (c == R + 3) begin
                inDataWr = 1'b1; #1;
                n_cmp++;
                if (outDataExtWr !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ext obs=%b exp=0", outDataExtWr); end
            end else if (c == R + 4) begin
                n_cmp++;
                if (outDataExtWr !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_ext obs=%b exp=1", outDataExtWr); end
            end else if (c == R + 5) begin
                inDataWr = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk); inKeyWr = 1'b1; inDataWr = 1'b1;
        for (int c = 1; c <= 140; c++) sb.push_back(model(c, 1, 1, 1));
        sb.push_back('0);
        @(posedge clk); #1; inKeyWr = 1'b0; inDataWr = 1'b0;
        for (int c = 1; c <= 141; c++) begin
            o = sample(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL rstmid c=%0d obs=%h exp=%h", c, o, e); end
            if (c == 140) inReset = 1'b1;
            if (c == 141) inReset = 1'b0;
            @(posedge clk); #1;
        end
        @(negedge clk); inDataWr = 1'b1; #1;
        n_cmp++;
        if (outDataExtWr !== 1'b0) begin n_fail++; $display("FAIL rstmid_ext obs=%b exp=0", outDataExtWr); end
        for (int c = 1; c <= 4; c++) sb.push_back(model(c, 0, 0, 0));
        @(posedge clk); #1; inDataWr = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            o = sample(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL rstmid_idle c=%0d obs=%h exp=%h", c, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_key_only_busy_ignore();
        @(negedge clk); inKeyWr = 1'b1; #1;
        n_cmp++;
        if ({outKeyExtWr, outDataExtWr} !== 2'b10) begin
            n_fail++; $display("FAIL konly_ext obs=%b exp=10", {outKeyExtWr, outDataExtWr});
        end
        for (int c = 1; c <= KSTEPS + 3; c++) sb.push_back(model(c, 1, 0, 0));
        @(posedge clk); #1; inKeyWr = 1'b0;
        for (int c = 1; c <= KSTEPS + 3; c++) begin
            o = sample(); e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_fail++; $display("FAIL konly c=%0d obs=%h exp=%h", c, o, e); end
            if (c == 50) begin
                inKeyWr = 1'b1; inDataWr = 1'b1; #1;
                n_cmp++;
                if ({outKeyExtWr, outDataExtWr} !== 2'b00) begin
                    n_fail++; $display("FAIL busy_ext obs=%b exp=00", {outKeyExtWr, outDataExtWr});
                end
            end else if (c == 51) begin
                inKeyWr = 1'b0; inDataWr = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_data_without_key();
        test_full_request();
        test_data_only();
        test_back_to_back();
        test_reset_mid_op();
        test_key_only_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached obs=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
